// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller with timed dwells and an optional pedestrian phase.
// The pedestrian phase is built only when TRAFFIC_PED_REQ_EN is defined.
module traffic_light_ctrl #(
    parameter int GRN_CYC    = 8,
    parameter int YEL_CYC    = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 6,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [2:0] ns_o,
    output logic [2:0] ew_o,
    output logic       walk,
    output logic [2:0] state_o
);

    localparam logic [2:0] S_NS_GRN = 3'd0;
    localparam logic [2:0] S_NS_YEL = 3'd1;
    localparam logic [2:0] S_AR1    = 3'd2;
    localparam logic [2:0] S_EW_GRN = 3'd3;
    localparam logic [2:0] S_EW_YEL = 3'd4;
    localparam logic [2:0] S_AR2    = 3'd5;
    localparam logic [2:0] S_WALK   = 3'd6;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_GRN = 3'b010;
    localparam logic [2:0] L_YEL = 3'b001;

    localparam logic [CNT_W-1:0] GRN_LD  = CNT_W'(GRN_CYC - 1);
    localparam logic [CNT_W-1:0] YEL_LD  = CNT_W'(YEL_CYC - 1);
    localparam logic [CNT_W-1:0] AR_LD   = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(WALK_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic [2:0]       nxt;
    logic [CNT_W-1:0] nxt_ld;
    logic             req_set;

    always_comb begin
        nxt = S_NS_GRN;
        case (state_q)
            S_NS_GRN: nxt = S_NS_YEL;
            S_NS_YEL: nxt = S_AR1;
            S_AR1:    nxt = S_EW_GRN;
            S_EW_GRN: nxt = S_EW_YEL;
            S_EW_YEL: nxt = S_AR2;
            S_AR2:    nxt = pending_q ? S_WALK : S_NS_GRN;
            default:  nxt = S_NS_GRN;
        endcase
    end

    always_comb begin
        nxt_ld = GRN_LD;
        case (nxt)
            S_NS_YEL, S_EW_YEL: nxt_ld = YEL_LD;
            S_AR1, S_AR2:       nxt_ld = AR_LD;
            S_WALK:             nxt_ld = WALK_LD;
            default:            nxt_ld = GRN_LD;
        endcase
    end

    // Code 7 leaves immediately; otherwise leave only once the timer hits 0.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (state_q == 3'd7 || timer_q == '0) begin
            state_d = nxt;
            timer_d = nxt_ld;
        end else begin
            timer_d = timer_q - 1'b1;
        end
    end

`ifdef TRAFFIC_PED_REQ_EN
    always_comb begin
        req_set   = ped_req && !pending_q && (state_q != S_WALK);
        pending_d = (state_d == S_WALK) ? 1'b0 : (pending_q | req_set);
        ack_d     = req_set;
    end

    assign walk = (state_q == S_WALK);
`else
    logic ped_req_unused;
    assign ped_req_unused = ped_req;

    always_comb begin
        req_set   = 1'b0;
        pending_d = 1'b0;
        ack_d     = req_set;
    end

    assign walk = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_NS_GRN;
            timer_q   <= GRN_LD;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        ns_o = L_RED;
        ew_o = L_RED;
        case (state_q)
            S_NS_GRN: ns_o = L_GRN;
            S_NS_YEL: ns_o = L_YEL;
            S_EW_GRN: ew_o = L_GRN;
            S_EW_YEL: ew_o = L_YEL;
            default: begin
                ns_o = L_RED;
                ew_o = L_RED;
            end
        endcase
    end

    assign ped_ack = ack_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: default instance plus a 1-cycle-dwell instance.
// Pedestrian scenarios run only when TRAFFIC_PED_REQ_EN is defined.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ped_req = 1'b0;
    logic       ped_ack, walk;
    logic [2:0] ns_o, ew_o, state_o;

    logic       f_req = 1'b0;
    logic       f_ack, f_walk;
    logic [2:0] f_ns, f_ew, f_state;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    traffic_light_ctrl u_dut (
        .clk(clk), .rst(rst), .ped_req(ped_req), .ped_ack(ped_ack),
        .ns_o(ns_o), .ew_o(ew_o), .walk(walk), .state_o(state_o)
    );

    traffic_light_ctrl #(.GRN_CYC(1), .YEL_CYC(1), .ALLRED_CYC(1)) u_fast (
        .clk(clk), .rst(rst), .ped_req(f_req), .ped_ack(f_ack),
        .ns_o(f_ns), .ew_o(f_ew), .walk(f_walk), .state_o(f_state)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [2:0] ns_of(input int s);
        case (s)
            0: return 3'b010;
            1: return 3'b001;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_of(input int s);
        case (s)
            3: return 3'b010;
            4: return 3'b001;
            default: return 3'b100;
        endcase
    endfunction

    task automatic push(input int s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s);
    endtask

    task automatic push_period(input bit with_walk);
        push(0, 8); push(1, 3); push(2, 2);
        push(3, 8); push(4, 3); push(5, 2);
        if (with_walk) push(6, 6);
    endtask

    // Holds rst for ncyc edges, then checks reset outputs and releases.
    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        ped_req = 1'b0;
        repeat (ncyc) @(negedge clk);
        chk("rst_state", state_o, 0);
        chk("rst_ns", ns_o, 3'b010);
        chk("rst_ew", ew_o, 3'b100);
        chk("rst_walk", walk, 0);
        chk("rst_ack", ped_ack, 0);
        chk("rst_fast_state", f_state, 0);
        rst = 1'b0;
    endtask

    // Cycle k=0 is the cycle right after reset release; exp_q holds states.
    task automatic run_seq(input int n, input int req_lo, input int req_hi,
                           input bit toggle, input int ack_a, input int ack_b);
        int s;
        for (int k = 0; k < n; k++) begin
            s = exp_q[k];
            chk("state", state_o, s);
            chk("ns", ns_o, ns_of(s));
            chk("ew", ew_o, ew_of(s));
            chk("walk", walk, (s == 6) ? 1 : 0);
            chk("ack", ped_ack, (k == ack_a || k == ack_b) ? 1 : 0);
            chk("fast_state", f_state, k % 6);
            chk("fast_not_both", ((f_ns != 3'b100) && (f_ew != 3'b100)) ? 1 : 0, 0);
            if (toggle) ped_req = k[0];
            else ped_req = (k >= req_lo && k < req_hi);
            @(negedge clk);
        end
        ped_req = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);
        exp_q.delete();
        push_period(0); push_period(0);
`ifdef TRAFFIC_PED_REQ_EN
        run_seq(52, -1, -1, 0, -1, -1);
`else
        run_seq(52, -1, -1, 1, -1, -1);
`endif

        // reset mid EW_GRN, then a clean period
        do_reset(1);
        run_seq(15, -1, -1, 0, -1, -1);
        do_reset(1);
        run_seq(26, -1, -1, 0, -1, -1);

`ifdef TRAFFIC_PED_REQ_EN
        // single pulse during EW_GRN
        do_reset(1);
        exp_q.delete();
        push_period(1); push_period(0);
        run_seq(58, 14, 15, 0, 15, -1);

        // reset on third WALK cycle discards the phase
        do_reset(1);
        run_seq(28, 14, 15, 0, 15, -1);
        do_reset(1);
        exp_q.delete();
        push_period(0);
        run_seq(26, -1, -1, 0, -1, -1);

        // held request: one ack, WALK, re-ack after WALK, second WALK
        do_reset(1);
        exp_q.delete();
        push_period(1); push_period(1); push(0, 2);
        run_seq(66, 0, 40, 0, 1, 33);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter GRN_CYC, default 8, green dwell in clk cycles for each direction (>=1).
REQ-002 Parameter YEL_CYC, default 3, yellow dwell in cycles (>=1).
REQ-003 Parameter ALLRED_CYC, default 2, all-red clearance dwell in cycles (>=1).
REQ-004 Parameter WALK_CYC, default 6, pedestrian walk dwell in cycles (>=1).
REQ-005 Parameter CNT_W, default 8, dwell timer width; every dwell parameter SHALL be <= 2^CNT_W.
REQ-006 clk  input  1  single clock; all state changes on posedge clk.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 ped_req  input  1  pedestrian request, level or pulse, sampled on posedge clk.
REQ-009 ped_ack  output  1  one-cycle acknowledge of a newly latched request.
REQ-010 ns_o  output  3  north-south lamps, one-hot: 100 red, 010 green, 001 yellow.
REQ-011 ew_o  output  3  east-west lamps, same encoding as ns_o.
REQ-012 walk  output  1  pedestrian walk lamp.
REQ-013 state_o  output  3  current state code (debug).

Function
REQ-014 States and codes SHALL be: NS_GRN=0, NS_YEL=1, AR1=2, EW_GRN=3, EW_YEL=4, AR2=5, WALK=6; code 7 SHALL be treated as NS_GRN on the next edge.
REQ-015 Cycle order SHALL be NS_GRN -> NS_YEL -> AR1 -> EW_GRN -> EW_YEL -> AR2 -> NS_GRN, or AR2 -> WALK -> NS_GRN when a request is pending at AR2 exit.
REQ-016 Each state SHALL last exactly its dwell parameter in cycles: the timer loads dwell-1 on entry, decrements each cycle, and the state advances on the edge where the timer is 0.
REQ-017 Lamp outputs SHALL be Moore-decoded from the registered state only: NS_GRN ns=010/ew=100; NS_YEL ns=001/ew=100; AR1, AR2, WALK ns=100/ew=100; EW_GRN ns=100/ew=010; EW_YEL ns=100/ew=001.
REQ-018 No state SHALL present green or yellow on both directions at once; invalid state code SHALL decode to both red.
REQ-019 walk SHALL be 1 only in WALK.
REQ-020 A pending latch SHALL set on any edge where ped_req=1 and pending=0 and the state is not WALK; ped_ack SHALL be 1 for exactly the following cycle.
REQ-021 ped_req held high or re-asserted while pending=1 SHALL generate no further ped_ack.
REQ-022 pending SHALL clear on entry to WALK; ped_req during WALK SHALL be ignored and SHALL produce no ack; it must be re-asserted after WALK.
REQ-023 A request latched on the same edge that AR2 exits SHALL NOT divert that exit; it SHALL be served at the next AR2.
REQ-024 Timer arithmetic SHALL be unsigned CNT_W bits with no wrap: the timer is reloaded before it can underflow.

Reset
REQ-025 While rst=1 at posedge clk, next state SHALL be NS_GRN, timer=GRN_CYC-1, pending=0, ped_ack=0.
REQ-026 Reset values SHALL be: ns_o=010, ew_o=100, walk=0, ped_ack=0, state_o=0.
REQ-027 Reset asserted mid-dwell, including during WALK, SHALL abort the dwell and discard any pending request.

Configuration
REQ-028 Macro TRAFFIC_PED_REQ_EN SHALL gate the pedestrian feature.
REQ-029 With TRAFFIC_PED_REQ_EN defined, REQ-008, REQ-009, REQ-012 and REQ-020 to REQ-023 SHALL apply.
REQ-030 Without TRAFFIC_PED_REQ_EN, ped_req SHALL be ignored, ped_ack and walk SHALL be constant 0, and WALK SHALL be unreachable; the port list is unchanged.

Verification
REQ-031 Default params, rst for 2 cycles, then idle: ns_o=010 for 8 cycles, 001 for 3, both 100 for 2, ew_o=010 for 8, 001 for 3, both red for 2; period 26 cycles, repeating.
REQ-032 Macro on, 1-cycle ped_req pulse during EW_GRN: ped_ack=1 for 1 cycle; after AR2, walk=1 with both red for 6 cycles; then NS_GRN; period 32.
REQ-033 Macro on, ped_req held high for 40 cycles: exactly one ped_ack before WALK; a new ack on the first cycle after WALK exits; the second WALK follows the next AR2.
REQ-034 rst asserted on the 3rd WALK cycle: next cycle state_o=0, ns_o=010, walk=0, pending=0; no WALK in the following 26-cycle period.
REQ-035 Macro off, ped_req toggled every cycle: ped_ack=0 and walk=0 throughout; 26-cycle period unchanged.
REQ-036 Params GRN_CYC=1, YEL_CYC=1, ALLRED_CYC=1: every state lasts 1 cycle; 6-cycle period; never green or yellow on both directions.
